// File: rtl/rx_fsm.sv
// rx_fsm: endpoint receive engine, flits -> per-ID RX slots
// plus trailing-CRC check and completion report
package rx_pkg;
  localparam int PKT_LENGTH_WIDTH = 8;

  typedef struct packed {
    logic [1:0] vc;
    logic [3:0] id;
    logic       req;
  } metadata_t;

  typedef struct packed {
    metadata_t   metadata;
    logic [31:0] payload;
  } flit_t;

  typedef enum logic [3:0] {
    FMT_LONG_READ  = 4'h0,
    FMT_LONG_WRITE = 4'h1,
    FMT_MEM_RESP   = 4'h2,
    FMT_SWITCH_CFG = 4'h3
  } fmt_t;

  typedef struct packed {
    fmt_t        format;
    logic [20:0] rsvd;
    logic [6:0]  length;
  } long_hdr_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  function automatic logic [PKT_LENGTH_WIDTH-1:0]
    expected_num_flits(long_hdr_t h);
    if (h.format == FMT_SWITCH_CFG)
      return {1'b0, h.length} + 8'd1;
    return {1'b0, h.length} + 8'd2;
  endfunction

  function automatic logic [31:0] crc_step(
    logic [31:0] c, logic [31:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction
endpackage

module rx_fsm
  import rx_pkg::*;
#(
  parameter int          NUM_MSGS     = 4,
  parameter logic [31:0] RX_BASE_ADDR = 32'h2000,
  parameter int          SLOT_WORDS   = 32,
  localparam int         IDW          = $clog2(NUM_MSGS),
  localparam int         LW           = PKT_LENGTH_WIDTH
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           flit_valid,
  input  flit_t          flit_in,
  output logic           flit_ready,
  output logic [31:0]    mem_addr,
  output logic           mem_wen,
  output logic [31:0]    mem_wdata,
  output logic [3:0]     mem_strobe,
  input  logic           mem_request_stall,
  output logic           done_valid,
  output logic [IDW-1:0] done_id,
  output logic [LW-1:0]  done_len,
  output logic           done_crc_err,
  output logic           done_ovf,
  output logic [7:0]     crc_err_count
);
  localparam logic [31:0] SLOT_BYTES = 32'(SLOT_WORDS * 4);

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic           cfg_q, cfg_d;
  logic [LW-1:0]  words_q, words_d;
  logic [LW-1:0]  idx_q, idx_d;
  logic [31:0]    crc_q, crc_d;
  logic           ovf_q, ovf_d;
  logic           done_valid_q, done_valid_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic [LW-1:0]  done_len_q, done_len_d;
  logic           done_crc_err_q, done_crc_err_d;
  logic           done_ovf_q, done_ovf_d;
  logic [7:0]     cnt_q, cnt_d;

  long_hdr_t      hdr;
  logic [LW-1:0]  hdr_words;
  logic [IDW-1:0] wid;
  logic [LW-1:0]  widx;
  logic           in_slot;
  logic           crc_done;
  logic           unused_bits;

  // CRC advances a whole word per cycle, so it is never busy
  assign crc_done    = 1'b1;
  assign unused_bits = ^{flit_in.metadata, hdr};

  assign hdr     = long_hdr_t'(flit_in.payload);
  assign wid     = (state_q == IDLE) ?
                   flit_in.metadata.id[IDW-1:0] : id_q;
  assign widx    = (state_q == IDLE) ? '0 : idx_q;
  assign in_slot = {{(32-LW){1'b0}}, widx} < SLOT_WORDS;

  always_comb begin
    hdr_words = expected_num_flits(hdr);
    if (hdr.format != FMT_SWITCH_CFG)
      hdr_words = hdr_words - LW'(1);

    state_d        = state_q;
    id_d           = id_q;
    cfg_d          = cfg_q;
    words_d        = words_q;
    idx_d          = idx_q;
    crc_d          = crc_q;
    ovf_d          = ovf_q;
    done_valid_d   = 1'b0;
    done_id_d      = '0;
    done_len_d     = '0;
    done_crc_err_d = 1'b0;
    done_ovf_d     = 1'b0;
    cnt_d          = cnt_q;
    flit_ready     = 1'b0;

    unique case (state_q)
      IDLE: begin
        crc_d      = '0;
        flit_ready = flit_valid && !mem_request_stall;
        if (flit_ready) begin
          id_d    = wid;
          cfg_d   = (hdr.format == FMT_SWITCH_CFG);
          words_d = hdr_words;
          idx_d   = LW'(1);
          ovf_d   = 1'b0;
          crc_d   = crc_step('0, flit_in.payload);
          if (hdr_words != LW'(1)) begin
            state_d = DATA;
          end else if (hdr.format == FMT_SWITCH_CFG) begin
            state_d      = DONE;
            done_valid_d = 1'b1;
            done_id_d    = wid;
            done_len_d   = hdr_words;
          end else begin
            state_d = CRC;
          end
        end
      end
      DATA: begin
        flit_ready = flit_valid && !mem_request_stall && crc_done;
        if (flit_ready) begin
          idx_d = idx_q + LW'(1);
          crc_d = crc_step(crc_q, flit_in.payload);
          ovf_d = ovf_q | ~in_slot;
          if (idx_q == words_q - LW'(1)) begin
            if (cfg_q) begin
              state_d      = DONE;
              done_valid_d = 1'b1;
              done_id_d    = id_q;
              done_len_d   = words_q;
              done_ovf_d   = ovf_q | ~in_slot;
            end else begin
              state_d = CRC;
            end
          end
        end
      end
      CRC: begin
        flit_ready = flit_valid && crc_done;
        if (flit_ready) begin
          state_d        = DONE;
          done_valid_d   = 1'b1;
          done_id_d      = id_q;
          done_len_d     = words_q;
          done_crc_err_d = (flit_in.payload != crc_q);
          done_ovf_d     = ovf_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (done_crc_err_q && cnt_q != 8'hFF)
          cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    mem_wen = flit_ready && in_slot &&
              (state_q == IDLE || state_q == DATA);
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_strobe = '0;
    if (mem_wen) begin
      mem_addr   = RX_BASE_ADDR
                 + ({{(32-IDW){1'b0}}, wid} * SLOT_BYTES)
                 + ({{(32-LW){1'b0}}, widx} << 2);
      mem_wdata  = flit_in.payload;
      mem_strobe = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      id_q           <= '0;
      cfg_q          <= 1'b0;
      words_q        <= '0;
      idx_q          <= '0;
      crc_q          <= '0;
      ovf_q          <= 1'b0;
      done_valid_q   <= 1'b0;
      done_id_q      <= '0;
      done_len_q     <= '0;
      done_crc_err_q <= 1'b0;
      done_ovf_q     <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      cfg_q          <= cfg_d;
      words_q        <= words_d;
      idx_q          <= idx_d;
      crc_q          <= crc_d;
      ovf_q          <= ovf_d;
      done_valid_q   <= done_valid_d;
      done_id_q      <= done_id_d;
      done_len_q     <= done_len_d;
      done_crc_err_q <= done_crc_err_d;
      done_ovf_q     <= done_ovf_d;
      cnt_q          <= cnt_d;
    end
  end

  assign done_valid    = done_valid_q;
  assign done_id       = done_id_q;
  assign done_len      = done_len_q;
  assign done_crc_err  = done_crc_err_q;
  assign done_ovf      = done_ovf_q;
  assign crc_err_count = cnt_q;
endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: directed packets against a queue model of the RX engine
// expected writes/completions built from packet contents and a table CRC
`timescale 1ns/1ps
module tb_rx_fsm;
  import rx_pkg::*;

  localparam int          SW   = 32;
  localparam logic [31:0] BASE = 32'h2000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        flit_valid;
  flit_t       flit_in;
  logic        flit_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strobe;
  logic        mem_request_stall;
  logic        done_valid;
  logic [1:0]  done_id;
  logic [7:0]  done_len;
  logic        done_crc_err;
  logic        done_ovf;
  logic [7:0]  crc_err_count;

  always #5 clk = ~clk;

  rx_fsm #(
    .NUM_MSGS(4), .RX_BASE_ADDR(BASE), .SLOT_WORDS(SW)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .flit_valid(flit_valid), .flit_in(flit_in),
    .flit_ready(flit_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_strobe(mem_strobe),
    .mem_request_stall(mem_request_stall),
    .done_valid(done_valid), .done_id(done_id),
    .done_len(done_len), .done_crc_err(done_crc_err),
    .done_ovf(done_ovf), .crc_err_count(crc_err_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] len;
    logic       err;
    logic       ovf;
  } dn_t;

  wr_t         exp_wr[$];
  dn_t         exp_dn[$];
  logic [31:0] wlog[$];
  logic [31:0] t1_log[$];
  dn_t         dlog[$];
  logic [31:0] tbl[256];
  int          vectors = 0;
  int          miscompares = 0;
  wr_t         cw;
  dn_t         cd;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  task automatic build_tbl();
    logic [31:0] c;
    for (int b = 0; b < 256; b++) begin
      c = 32'(b) << 24;
      for (int k = 0; k < 8; k++)
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      tbl[b] = c;
    end
  endtask

  // Byte-wise table CRC over the words, MSB byte first, init 0
  function automatic logic [31:0] crc_words(input logic [31:0] w[$]);
    logic [31:0] c;
    logic [7:0]  by;
    c = '0;
    foreach (w[i])
      for (int b = 3; b >= 0; b--) begin
        by = w[i][8*b +: 8];
        c  = (c << 8) ^ tbl[c[31:24] ^ by];
      end
    return c;
  endfunction

  always @(negedge clk) begin
    if (n_rst) begin
      chk("ready_without_valid", 32'(flit_ready & ~flit_valid), 0);
      if (mem_wen) begin
        chk("wen_under_stall", 32'(mem_request_stall), 0);
        chk("wr_strobe", 32'(mem_strobe), 32'hF);
        wlog.push_back(mem_addr);
        if (exp_wr.size() == 0) begin
          fail("unexpected_write");
        end else begin
          cw = exp_wr.pop_front();
          chk("wr_addr", mem_addr, cw.addr);
          chk("wr_data", mem_wdata, cw.data);
        end
      end
      if (done_valid) begin
        cd = '{done_id, done_len, done_crc_err, done_ovf};
        dlog.push_back(cd);
        if (exp_dn.size() == 0) begin
          fail("unexpected_done");
        end else begin
          cd = exp_dn.pop_front();
          chk("done_id", 32'(done_id), 32'(cd.id));
          chk("done_len", 32'(done_len), 32'(cd.len));
          chk("done_crc_err", 32'(done_crc_err), 32'(cd.err));
          chk("done_ovf", 32'(done_ovf), 32'(cd.ovf));
        end
      end else begin
        chk("done_fields_idle",
            32'({done_id, done_len, done_crc_err, done_ovf}), 0);
      end
    end
  end

  task automatic send_pkt(input logic [1:0] id, input fmt_t fmt,
                          input int len, input bit bad_crc,
                          input int stall_at, input int stall_n,
                          input int n_send, output int stall_waits);
    logic [31:0] words[$];
    logic [31:0] c;
    flit_t       f;
    int          nw, nf, ns, waits, st;
    bit          ok;
    words.push_back({fmt, 21'h0, 7'(len)});
    for (int i = 0; i < len; i++)
      words.push_back(32'hD000_0000 | (32'(id) << 16) | 32'(i));
    nw = words.size();
    c  = crc_words(words);
    nf = (fmt == FMT_SWITCH_CFG) ? nw : nw + 1;
    ns = (n_send < 0) ? nf : n_send;
    for (int i = 0; i < nw && i < ns && i < SW; i++)
      exp_wr.push_back('{BASE + 32'(id) * SW * 4 + 32'(i) * 4,
                         words[i]});
    if (ns == nf)
      exp_dn.push_back('{id, 8'(nw),
                         bad_crc && fmt != FMT_SWITCH_CFG,
                         nw > SW});
    if (fmt != FMT_SWITCH_CFG)
      words.push_back(c ^ (bad_crc ? 32'h1 : 32'h0));
    stall_waits = 0;
    for (int i = 0; i < ns; i++) begin
      st = (i == stall_at) ? stall_n : 0;
      f.metadata.vc  = 2'(i);
      f.metadata.id  = {2'b01, id};
      f.metadata.req = 1'b1;
      f.payload      = words[i];
      ok    = 1'b0;
      waits = 0;
      for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
        mem_request_stall = (st > 0);
        if (st > 0) st--;
        flit_valid = 1'b1;
        flit_in    = f;
        @(negedge clk);
        ok = flit_ready;
        if (!ok) waits++;
        @(posedge clk);
        #1;
      end
      if (!ok) fail("flit_accept_timeout");
      if (i == stall_at) stall_waits = waits;
    end
    flit_valid        = 1'b0;
    mem_request_stall = 1'b0;
    flit_in           = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_dn.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_dn.size() > 0) begin
      fail("done_timeout");
      exp_dn.delete();
    end
    @(posedge clk);
    #1;
    chk("writes_drained", 32'(exp_wr.size()), 0);
    exp_wr.delete();
  endtask

  task automatic clear_logs();
    wlog.delete();
    dlog.delete();
  endtask

  initial begin
    logic [31:0] q[$];
    int sw;
    n_rst = 1'b0;
    flit_valid = 1'b0;
    flit_in = '0;
    mem_request_stall = 1'b0;
    build_tbl();

    q.push_back(32'h1);
    chk("model_crc_one", crc_words(q), 32'h04C11DB7);
    q.delete();
    q.push_back(32'h2);
    chk("model_crc_two", crc_words(q), 32'h09823B6E);

    #12;
    chk("rst_ready", 32'(flit_ready), 0);
    chk("rst_wen", 32'(mem_wen), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_done", 32'(done_valid), 0);
    chk("rst_cnt", 32'(crc_err_count), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: long write, id 2, good CRC
    clear_logs();
    send_pkt(2'd2, FMT_LONG_WRITE, 2, 1'b0, -1, 0, -1, sw);
    wait_done();
    chk("t1_nwr", 32'(wlog.size()), 3);
    chk("t1_a0", wlog[0], 32'h2100);
    chk("t1_a1", wlog[1], 32'h2104);
    chk("t1_a2", wlog[2], 32'h2108);
    chk("t1_ndone", 32'(dlog.size()), 1);
    chk("t1_len", 32'(dlog[0].len), 3);
    chk("t1_err", 32'(dlog[0].err), 0);
    t1_log = wlog;

    // 2: same packet, CRC bit 0 flipped
    clear_logs();
    send_pkt(2'd2, FMT_LONG_WRITE, 2, 1'b1, -1, 0, -1, sw);
    wait_done();
    chk("t2_err", 32'(dlog[0].err), 1);
    chk("t2_cnt", 32'(crc_err_count), 1);
    chk("t2_nwr", 32'(wlog.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("t2_same_addr", wlog[i], t1_log[i]);

    // 3: switch cfg, id 0, two words, no CRC flit
    clear_logs();
    send_pkt(2'd0, FMT_SWITCH_CFG, 1, 1'b0, -1, 0, -1, sw);
    wait_done();
    chk("t3_nwr", 32'(wlog.size()), 2);
    chk("t3_a0", wlog[0], 32'h2000);
    chk("t3_a1", wlog[1], 32'h2004);
    chk("t3_len", 32'(dlog[0].len), 2);
    chk("t3_err", 32'(dlog[0].err), 0);

    // 4: stall held 3 cycles on data word 1
    clear_logs();
    send_pkt(2'd3, FMT_LONG_WRITE, 2, 1'b0, 1, 3, -1, sw);
    wait_done();
    chk("t4_stall_waits", 32'(sw), 3);
    chk("t4_nwr", 32'(wlog.size()), 3);
    chk("t4_err", 32'(dlog[0].err), 0);

    // 5: 34 words into a 32-word slot
    clear_logs();
    send_pkt(2'd1, FMT_LONG_WRITE, 33, 1'b0, -1, 0, -1, sw);
    wait_done();
    chk("t5_nwr", 32'(wlog.size()), 32);
    chk("t5_first", wlog[0], 32'h2080);
    chk("t5_last", wlog[31], 32'h20FC);
    chk("t5_len", 32'(dlog[0].len), 34);
    chk("t5_ovf", 32'(dlog[0].ovf), 1);
    chk("t5_err", 32'(dlog[0].err), 0);

    // 6: reset after 2nd flit, then a clean packet
    clear_logs();
    send_pkt(2'd2, FMT_LONG_WRITE, 4, 1'b0, -1, 0, 2, sw);
    n_rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_cnt", 32'(crc_err_count), 0);
    chk("t6_rst_done", 32'(done_valid), 0);
    #2;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_abort_done", 32'(dlog.size()), 0);
    chk("t6_abort_writes", 32'(wlog.size()), 2);
    chk("t6_wr_drained", 32'(exp_wr.size()), 0);
    clear_logs();
    send_pkt(2'd0, FMT_LONG_WRITE, 3, 1'b0, -1, 0, -1, sw);
    wait_done();
    chk("t6_ndone", 32'(dlog.size()), 1);
    chk("t6_err", 32'(dlog[0].err), 0);
    chk("t6_len", 32'(dlog[0].len), 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
